// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT MCU port-bus responder: port addresses and IRQ bit layout.
package rat_io_pkg;

  localparam logic [7:0] PID_SW   = 8'h20;
  localparam logic [7:0] PID_BTN  = 8'h24;
  localparam logic [7:0] PID_PEND = 8'h30;
  localparam logic [7:0] PID_MASK = 8'h31;
  localparam logic [7:0] PID_ACK  = 8'h32;
  localparam logic [7:0] PID_TMR  = 8'h33;
  localparam logic [7:0] PID_LEDS = 8'h40;
  localparam logic [7:0] PID_SSEG = 8'h81;

  localparam int unsigned NUM_IRQ  = 5;
  localparam int unsigned IRQ_BTN0 = 0;
  localparam int unsigned IRQ_BTN1 = 1;
  localparam int unsigned IRQ_BTN2 = 2;
  localparam int unsigned IRQ_BTN3 = 3;
  localparam int unsigned IRQ_TMR  = 4;

endpackage

// File: rtl/rat_io_timer.sv
// Interval timer: prescaler feeding an 8-bit reload down-counter; reload of 0 stops it.
module rat_io_timer #(
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] reload,
  input  logic       reload_wr,
  output logic       tick_out
);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wrap;

  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    wrap     = (cnt_q != 8'd0) && (presc_q == PRESCALE - 16'd1);
    // A reload write restarts the period, so it also swallows a coincident tick.
    tick_out = wrap && (cnt_q == 8'd1) && !reload_wr;
    if (reload_wr) begin
      presc_d = 16'd0;
      cnt_d   = reload;
    end else if (cnt_q != 8'd0) begin
      if (wrap) begin
        presc_d = 16'd0;
        cnt_d   = (cnt_q == 8'd1) ? reload : cnt_q - 8'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      presc_q <= 16'd0;
      cnt_q   <= 8'd0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rat_io_responder.sv
// Peripheral side of the RAT MCU port bus: write decode, read mux, input sync and IRQ control.
// Define RAT_IO_DEBOUNCE_EN to add per-button debounce counters (DEB_CYCLES stable cycles).
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd50000
`ifdef RAT_IO_DEBOUNCE_EN
  , parameter logic [15:0] DEB_CYCLES = 16'd1000
`endif
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTV,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG
);

  logic [7:0]         sw_meta, sw_sync;
  logic [3:0]         btn_meta, btn_sync, btn_prev, btn_val, btn_rise;
  logic [2:0]         init_q;
  logic               armed;
  logic [7:0]         leds_q, leds_d, sseg_q, sseg_d, tmr_q, tmr_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, pend_q, pend_d, ack, set;
  logic               intv_q, intv_d, tmr_wr, tick;

  // Edge detection stays off for a few cycles after reset so that buttons held through
  // reset settle into btn_prev instead of firing.
  assign armed = (init_q == 3'd7);

`ifdef RAT_IO_DEBOUNCE_EN
  logic [3:0]  deb_q, deb_d;
  logic [15:0] deb_cnt_q [4];
  logic [15:0] deb_cnt_d [4];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = 16'd0;
      if (!armed) begin
        deb_d[i] = btn_sync[i];
      end else if (btn_sync[i] != deb_q[i]) begin
        if (deb_cnt_q[i] + 16'd1 >= DEB_CYCLES) deb_d[i] = btn_sync[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      deb_q <= 4'd0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= 16'd0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign btn_val = deb_q;
`else
  assign btn_val = btn_sync;
`endif

  assign btn_rise = armed ? (btn_val & ~btn_prev) : 4'd0;
  assign tmr_wr   = IO_STRB && (PORT_ID == PID_TMR);

  always_comb begin
    leds_d = leds_q;
    sseg_d = sseg_q;
    tmr_d  = tmr_q;
    mask_d = mask_q;
    ack    = '0;
    if (IO_STRB) begin
      unique case (PORT_ID)
        PID_LEDS: leds_d = OUT_PORT;
        PID_SSEG: sseg_d = OUT_PORT;
        PID_TMR:  tmr_d  = OUT_PORT;
        PID_MASK: mask_d = OUT_PORT[NUM_IRQ-1:0];
        PID_ACK:  ack    = OUT_PORT[NUM_IRQ-1:0];
        default:  ;
      endcase
    end
    set                = '0;
    set[IRQ_BTN0 +: 4] = btn_rise;
    set[IRQ_TMR]       = tick;
    // Set beats ack so an event arriving during the ISR's ack is never dropped.
    pend_d = (pend_q & ~ack) | set;
    intv_d = |(pend_d & mask_d);
  end

  always_comb begin
    IN_PORT = 8'h00;
    unique case (PORT_ID)
      PID_SW:   IN_PORT = sw_sync;
      PID_BTN:  IN_PORT = {4'd0, btn_val};
      PID_PEND: IN_PORT = {3'd0, pend_q};
      PID_MASK: IN_PORT = {3'd0, mask_q};
      PID_TMR:  IN_PORT = tmr_q;
      PID_LEDS: IN_PORT = leds_q;
      PID_SSEG: IN_PORT = sseg_q;
      default:  IN_PORT = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sw_meta  <= 8'd0;
      sw_sync  <= 8'd0;
      btn_meta <= 4'd0;
      btn_sync <= 4'd0;
      btn_prev <= 4'd0;
      init_q   <= 3'd0;
      leds_q   <= 8'd0;
      sseg_q   <= 8'd0;
      tmr_q    <= 8'd0;
      mask_q   <= '0;
      pend_q   <= '0;
      intv_q   <= 1'b0;
    end else begin
      sw_meta  <= SWITCHES;
      sw_sync  <= sw_meta;
      btn_meta <= BUTTONS;
      btn_sync <= btn_meta;
      btn_prev <= btn_val;
      init_q   <= armed ? init_q : init_q + 3'd1;
      leds_q   <= leds_d;
      sseg_q   <= sseg_d;
      tmr_q    <= tmr_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      intv_q   <= intv_d;
    end
  end

  rat_io_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk      (clk),
    .RESET    (RESET),
    .reload   (tmr_d),
    .reload_wr(tmr_wr),
    .tick_out (tick)
  );

  assign LEDS = leds_q;
  assign SSEG = sseg_q;
  assign INTV = intv_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed bench for rat_io_responder: register table plus button, mask, timer and reset sequences.
module tb_rat_io_responder;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] PORT_ID, OUT_PORT, IN_PORT, SWITCHES, LEDS, SSEG;
  logic       IO_STRB, INTV;
  logic [3:0] BUTTONS;

  always #5 clk = ~clk;

`ifdef RAT_IO_DEBOUNCE_EN
  localparam int BTN_LAT = 3 + 8;
`else
  localparam int BTN_LAT = 3;
`endif

  rat_io_responder #(
    .PRESCALE(16'd4)
`ifdef RAT_IO_DEBOUNCE_EN
    , .DEB_CYCLES(16'd8)
`endif
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .INTV    (INTV),
    .SWITCHES(SWITCHES),
    .BUTTONS (BUTTONS),
    .LEDS    (LEDS),
    .SSEG    (SSEG)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       strb;
    logic [7:0] pid;
    logic [7:0] data;
    logic [7:0] exp_in;
    logic [7:0] exp_leds;
    logic [7:0] exp_sseg;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] data);
    IO_STRB  = 1'b1;
    PORT_ID  = pid;
    OUT_PORT = data;
    step();
    IO_STRB  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] pid, input logic [7:0] exp);
    PORT_ID = pid;
    #1;
    check(name, IN_PORT, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h40, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 8'h55, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[2]  = '{1'b1, 8'h55, 8'hFF, 8'h00, 8'hA5, 8'h00};
    vecs[3]  = '{1'b1, 8'h81, 8'h3C, 8'h3C, 8'hA5, 8'h3C};
    vecs[4]  = '{1'b1, 8'h31, 8'hFF, 8'h1F, 8'hA5, 8'h3C};
    vecs[5]  = '{1'b1, 8'h31, 8'h00, 8'h00, 8'hA5, 8'h3C};
    vecs[6]  = '{1'b0, 8'h40, 8'h12, 8'hA5, 8'hA5, 8'h3C};
    vecs[7]  = '{1'b1, 8'h33, 8'h00, 8'h00, 8'hA5, 8'h3C};
    vecs[8]  = '{1'b0, 8'h20, 8'h00, 8'h5A, 8'hA5, 8'h3C};
    vecs[9]  = '{1'b0, 8'h30, 8'h00, 8'h00, 8'hA5, 8'h3C};
    vecs[10] = '{1'b1, 8'h32, 8'hFF, 8'h00, 8'hA5, 8'h3C};
    vecs[11] = '{1'b0, 8'h24, 8'h00, 8'h00, 8'hA5, 8'h3C};

    RESET    = 1'b1;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h30;
    OUT_PORT = 8'h00;
    SWITCHES = 8'h5A;
    BUTTONS  = 4'd0;
    repeat (2) step();
    check("reset_leds", LEDS, 8'h00);
    check("reset_sseg", SSEG, 8'h00);
    check("reset_intv", {7'd0, INTV}, 8'h00);
    rd_chk("reset_pend", 8'h30, 8'h00);
    RESET = 1'b0;
    repeat (10) step();

    for (int i = 0; i < 12; i++) begin
      IO_STRB  = vecs[i].strb;
      PORT_ID  = vecs[i].pid;
      OUT_PORT = vecs[i].data;
      step();
      IO_STRB = 1'b0;
      #1;
      check($sformatf("vec%0d_in", i), IN_PORT, vecs[i].exp_in);
      check($sformatf("vec%0d_leds", i), LEDS, vecs[i].exp_leds);
      check($sformatf("vec%0d_sseg", i), SSEG, vecs[i].exp_sseg);
    end

    // Button 0 rising edge with its IRQ enabled.
    wr(8'h31, 8'h01);
    BUTTONS[0] = 1'b1;
    repeat (BTN_LAT - 1) step();
    rd_chk("btn0_early", 8'h30, 8'h00);
    step();
    rd_chk("btn0_pend", 8'h30, 8'h01);
    check("btn0_intv", {7'd0, INTV}, 8'h01);
    repeat (3) step();
    check("btn0_intv_hold", {7'd0, INTV}, 8'h01);
    wr(8'h32, 8'h01);
    check("btn0_ack_intv", {7'd0, INTV}, 8'h00);
    rd_chk("btn0_ack_pend", 8'h30, 8'h00);
    repeat (6) step();
    rd_chk("btn0_no_refire", 8'h30, 8'h00);
    BUTTONS[0] = 1'b0;
    repeat (BTN_LAT + 2) step();

    // Masked button 1 still latches; unmasking raises INTV.
    wr(8'h31, 8'h00);
    BUTTONS[1] = 1'b1;
    repeat (BTN_LAT) step();
    rd_chk("btn1_masked_pend", 8'h30, 8'h02);
    check("btn1_masked_intv", {7'd0, INTV}, 8'h00);
    wr(8'h31, 8'h02);
    check("btn1_unmask_intv", {7'd0, INTV}, 8'h01);
    BUTTONS[1] = 1'b0;
    repeat (BTN_LAT + 2) step();
    rd_chk("btn1_still_pend", 8'h30, 8'h02);

    // Button 1 edge lands on the same edge as its ack: the set must survive.
    BUTTONS[1] = 1'b1;
    repeat (BTN_LAT - 1) step();
    wr(8'h32, 8'h02);
    rd_chk("collide_pend", 8'h30, 8'h02);
    check("collide_intv", {7'd0, INTV}, 8'h01);
    wr(8'h32, 8'h02);
    rd_chk("collide_ack_pend", 8'h30, 8'h00);
    check("collide_ack_intv", {7'd0, INTV}, 8'h00);
    BUTTONS[1] = 1'b0;
    repeat (BTN_LAT + 2) step();

    // Timer: PRESCALE=4, reload=3 gives a 12-cycle period.
    wr(8'h31, 8'h10);
    wr(8'h33, 8'h03);
    rd_chk("tmr_reload_rd", 8'h33, 8'h03);
    repeat (11) step();
    rd_chk("tmr_before_tick", 8'h30, 8'h00);
    step();
    rd_chk("tmr_tick1", 8'h30, 8'h10);
    check("tmr_intv", {7'd0, INTV}, 8'h01);
    wr(8'h32, 8'h10);
    repeat (10) step();
    rd_chk("tmr_before_tick2", 8'h30, 8'h00);
    step();
    rd_chk("tmr_tick2", 8'h30, 8'h10);
    wr(8'h33, 8'h00);
    wr(8'h32, 8'h10);
    repeat (30) step();
    rd_chk("tmr_disabled", 8'h30, 8'h00);
    check("tmr_disabled_intv", {7'd0, INTV}, 8'h00);

`ifdef RAT_IO_DEBOUNCE_EN
    BUTTONS[2] = 1'b1;
    repeat (5) step();
    BUTTONS[2] = 1'b0;
    repeat (20) step();
    rd_chk("deb_short_pulse", 8'h30, 8'h00);
    BUTTONS[2] = 1'b1;
    repeat (10) step();
    BUTTONS[2] = 1'b0;
    repeat (20) step();
    rd_chk("deb_long_pulse", 8'h30, 8'h04);
    wr(8'h32, 8'h04);
`endif

    // Reset in the middle of a write while an interrupt is active.
    wr(8'h31, 8'h02);
    BUTTONS[1] = 1'b1;
    repeat (BTN_LAT) step();
    check("pre_reset_intv", {7'd0, INTV}, 8'h01);
    IO_STRB  = 1'b1;
    PORT_ID  = 8'h40;
    OUT_PORT = 8'h77;
    #2;
    RESET = 1'b1;
    #1;
    check("midreset_leds", LEDS, 8'h00);
    check("midreset_intv", {7'd0, INTV}, 8'h00);
    rd_chk("midreset_pend", 8'h30, 8'h00);
    IO_STRB = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    repeat (15) step();
    rd_chk("held_btn_no_fire", 8'h30, 8'h00);
    rd_chk("post_reset_mask", 8'h31, 8'h00);
    check("post_reset_leds", LEDS, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
